// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-NCH valid/ready demultiplexer with one output register per channel.
// Define STREAM_DEMUX_ERR_EN to add sticky out-of-range select reporting (sel_err, err_cnt, err_clr).
module stream_demux #(
  parameter int DW  = 8,
  parameter int NCH = 8,
  parameter int SW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SW-1:0]     in_sel,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*DW-1:0] out_data
`ifdef STREAM_DEMUX_ERR_EN
  ,
  output logic              sel_err,
  output logic [7:0]        err_cnt,
  input  logic              err_clr
`endif
);
  localparam logic [SW:0] LP_NCH = (SW+1)'(NCH);
  logic [NCH-1:0]         r_vld;
  logic [NCH-1:0][DW-1:0] r_dat;
  logic [NCH-1:0]         w_hit;
  logic [NCH-1:0]         w_ld;
  logic                   w_in_range;
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < NCH; k++) w_hit[k] = in_sel == SW'(k);
  end
  // An out-of-range select hits no channel, so it is always ready and loads nothing.
  assign w_in_range = {1'b0, in_sel} < LP_NCH;
  assign in_ready   = !w_in_range || |(w_hit & (~r_vld | out_ready));
  assign w_ld       = {NCH{in_valid}} & w_hit & (~r_vld | out_ready);
  assign out_valid  = r_vld;
  assign out_data   = r_dat;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_dat <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_ld[k]) begin
          r_vld[k] <= 1'b1;
          r_dat[k] <= in_data;
        end else if (out_ready[k]) begin
          r_vld[k] <= 1'b0;
        end
      end
    end
  end
`ifdef STREAM_DEMUX_ERR_EN
  logic       r_sel_err;
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n || err_clr) begin
      r_sel_err <= 1'b0;
      r_err_cnt <= '0;
    end else if (in_valid && !w_in_range) begin
      r_sel_err <= 1'b1;
      r_err_cnt <= (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
    end
  end
  assign sel_err = r_sel_err;
  assign err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed checks of stream_demux at NCH=8 and NCH=5 (out-of-range selects).
module tb_stream_demux;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic [7:0]  out_valid, out_ready;
  logic [63:0] out_data;
  logic        in_valid5, in_ready5;
  logic [7:0]  in_data5;
  logic [2:0]  in_sel5;
  logic [4:0]  out_valid5, out_ready5;
  logic [39:0] out_data5;
`ifdef STREAM_DEMUX_ERR_EN
  logic        sel_err8, sel_err5, err_clr5;
  logic [7:0]  err_cnt8, err_cnt5;
`endif
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_demux #(.DW(8), .NCH(8), .SW(3)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
`ifdef STREAM_DEMUX_ERR_EN
    , .sel_err(sel_err8), .err_cnt(err_cnt8), .err_clr(1'b0)
`endif
  );

  stream_demux #(.DW(8), .NCH(5), .SW(3)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_data(in_data5), .in_sel(in_sel5), .out_valid(out_valid5),
    .out_ready(out_ready5), .out_data(out_data5)
`ifdef STREAM_DEMUX_ERR_EN
    , .sel_err(sel_err5), .err_cnt(err_cnt5), .err_clr(err_clr5)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '1;
    in_valid5 = 1'b0; in_data5 = '0; in_sel5 = '0; out_ready5 = '1;
`ifdef STREAM_DEMUX_ERR_EN
    err_clr5 = 1'b0;
`endif
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 3'(i); in_data = 8'hA0 + 8'(i);
      #1;
      chk("sweep_in_ready", 64'(in_ready), 64'h1);
      step();
      chk("sweep_onehot", 64'(out_valid), 64'(8'h01 << i));
      chk("sweep_data", 64'(out_data[i*8 +: 8]), 64'(8'hA0 + 8'(i)));
    end
    in_valid = 1'b0;
    step();
    chk("sweep_drained", 64'(out_valid), 64'h0);

    out_ready = 8'hF7;
    in_valid = 1'b1; in_sel = 3'd3; in_data = 8'h11;
    #1;
    chk("bp_first_ready", 64'(in_ready), 64'h1);
    step();
    chk("bp_ch3_valid", 64'(out_valid), 64'h08);
    in_data = 8'h22;
    #1;
    chk("bp_stall_ready", 64'(in_ready), 64'h0);
    step();
    chk("bp_ch3_hold", 64'(out_data[24 +: 8]), 64'h11);
    in_sel = 3'd5; in_data = 8'h33;
    #1;
    chk("bp_ch5_ready", 64'(in_ready), 64'h1);
    step();
    chk("bp_ch5_valid", 64'(out_valid), 64'h28);
    chk("bp_ch5_data", 64'(out_data[40 +: 8]), 64'h33);
    in_sel = 3'd3; in_data = 8'h22; out_ready = 8'hFF;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'h1);
    step();
    chk("bp_replace_valid", 64'(out_valid), 64'h08);
    chk("bp_replace_data", 64'(out_data[24 +: 8]), 64'h22);
    in_valid = 1'b0;
    step();
    chk("bp_drained", 64'(out_valid), 64'h0);

    for (int j = 0; j < 16; j++) begin
      in_valid = 1'b1; in_sel = 3'd0; in_data = 8'h40 + 8'(j);
      #1;
      chk("b2b_ready", 64'(in_ready), 64'h1);
      step();
      chk("b2b_valid", 64'(out_valid), 64'h01);
      chk("b2b_data", 64'(out_data[7:0]), 64'(8'h40 + 8'(j)));
    end
    in_valid = 1'b0;
    step();
    chk("b2b_drained", 64'(out_valid), 64'h0);

    in_valid5 = 1'b1; in_sel5 = 3'd4; in_data5 = 8'h5A;
    #1;
    chk("n5_top_ready", 64'(in_ready5), 64'h1);
    step();
    chk("n5_top_valid", 64'(out_valid5), 64'h10);
    chk("n5_top_data", 64'(out_data5[32 +: 8]), 64'h5A);
    in_sel5 = 3'd6; in_data5 = 8'hFF;
    #1;
    chk("n5_oor_ready", 64'(in_ready5), 64'h1);
    step();
    chk("n5_oor_no_valid", 64'(out_valid5), 64'h0);
    chk("n5_oor_data_kept", 64'(out_data5[32 +: 8]), 64'h5A);
`ifdef STREAM_DEMUX_ERR_EN
    chk("n5_sel_err", 64'(sel_err5), 64'h1);
    chk("n5_err_cnt1", 64'(err_cnt5), 64'h1);
`endif
    for (int j = 1; j < 300; j++) step();
    chk("n5_oor_many_valid", 64'(out_valid5), 64'h0);
`ifdef STREAM_DEMUX_ERR_EN
    chk("n5_err_sat", 64'(err_cnt5), 64'hFF);
    err_clr5 = 1'b1;
    step();
    err_clr5 = 1'b0;
    chk("n5_clr_sel_err", 64'(sel_err5), 64'h0);
    chk("n5_clr_err_cnt", 64'(err_cnt5), 64'h0);
`endif
    in_valid5 = 1'b0;
    step();

    out_ready = 8'h00;
    in_valid = 1'b1; in_sel = 3'd2; in_data = 8'h77;
    step();
    in_sel = 3'd7; in_data = 8'h88;
    step();
    in_valid = 1'b0; in_sel = 3'd2;
    #1;
    chk("fill_valid", 64'(out_valid), 64'h84);
    chk("fill_ch2_full", 64'(in_ready), 64'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("rst2_out_valid", 64'(out_valid), 64'h0);
    chk("rst2_out_data", out_data, 64'h0);
    chk("rst2_in_ready", 64'(in_ready), 64'h1);

    in_valid = 1'b1; in_sel = 3'd1; in_data = 8'h5C;
    step();
    in_valid = 1'b0; in_valid5 = 1'b0;
    for (int j = 0; j < 20; j++) begin
      in_sel = 3'($urandom); in_data = 8'($urandom);
      in_sel5 = 3'($urandom_range(5, 7)); in_data5 = 8'($urandom);
      step();
    end
    chk("idle_valid", 64'(out_valid), 64'h02);
    chk("idle_data", out_data, 64'h0000_0000_0000_5C00);
    chk("idle_valid5", 64'(out_valid5), 64'h0);
`ifdef STREAM_DEMUX_ERR_EN
    chk("idle_err_cnt", 64'(err_cnt5), 64'h0);
    chk("idle_sel_err", 64'(sel_err5), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1-to-NCH stream demultiplexer and the successor to the combinational 1-to-8 demux. It routes each input word, with a valid/ready handshake, to the output channel selected by `in_sel`. Every channel has a one-entry output register, so each consumer can apply its own backpressure. It sits between a single producer and NCH independent consumers. Optional out-of-range select error reporting is included.

## Interface
- `DW`, 8, data width in bits (≥1)
- `NCH`, 8, number of output channels (2..256; need not be a power of two)
- `SW`, 3, select width; must satisfy 2**SW ≥ NCH

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset; one clock, synchronous, active-low
- `in_valid`  in  1  producer word valid
- `in_ready`  out  1  block can accept the presented word
- `in_data`  in  DW  producer word
- `in_sel`  in  SW  destination channel index, sampled with `in_data`
- `out_valid`  out  NCH  per-channel word valid; bit i = channel i
- `out_ready`  in  NCH  per-channel consumer ready
- `out_data`  out  NCH*DW  flattened; channel i = bits [i*DW +: DW]
- `sel_err`  out  1  sticky out-of-range flag (only when `STREAM_DEMUX_ERR_EN` is defined)
- `err_cnt`  out  8  saturating dropped-word count (only when `STREAM_DEMUX_ERR_EN` is defined)
- `err_clr`  in  1  clears `sel_err` and `err_cnt` (only when `STREAM_DEMUX_ERR_EN` is defined)

## Operation
- Per channel i, state is `vld[i]` and `dat[i]`. Outputs: `out_valid[i]` = `vld[i]`; `out_data` slice i = `dat[i]`.
- In-range select (`in_sel` < NCH):
  - `in_ready` = !`vld[in_sel]` || `out_ready[in_sel]`. This is combinational from `in_sel`, `vld` and `out_ready`, and does not depend on `in_valid`.
- Out-of-range select (`in_sel` ≥ NCH):
  - `in_ready` = 1 and the word is discarded.
  - No channel state changes.
- Accept: `in_valid` && `in_ready` && in-range. Next edge: `dat[in_sel]` ← `in_data`, `vld[in_sel]` ← 1.
- Drain: `vld[i]` && `out_ready[i]`. Next edge: `vld[i]` ← 0, unless the same edge accepts into channel i.
- Simultaneous drain and accept on the same channel:
  - The new word replaces the old one and `vld` stays 1.
  - Sustains 1 word/cycle into one channel.
- Channels are independent. Drains on any set of channels can occur in the same cycle as an accept to another channel.
- `dat[i]` holds its last value when `vld[i]` = 0. It is not cleared after a drain.
- `in_valid` = 0 never changes state. `in_sel`/`in_data` are don't-care then.
- Reset (synchronous, `rst_n` = 0 at an edge):
  - all `vld` ← 0, all `dat` ← 0, `sel_err` ← 0, `err_cnt` ← 0.
  - Words held mid-transfer are lost.
  - While `rst_n` = 0, `in_ready` still follows the formula, but no accept takes effect.

## Timing
- Latency: word accepted at edge k is visible on `out_valid`/`out_data` from edge k (registered), i.e. one cycle after presentation.
- Throughput: 1 word/cycle aggregate, including back-to-back words to the same channel when its consumer is always ready.
- Backpressure: a full channel with `out_ready` = 0 stalls only words addressed to it. Words to other channels still proceed.
- Reset values: `out_valid` = 0, `out_data` = 0, `sel_err` = 0, `err_cnt` = 0. `in_ready` = 1 after reset (all channels empty).
- Combinational paths: `in_sel` → `in_ready` and `out_ready` → `in_ready` only. No path from `in_valid` to `in_ready`.

## Configuration
- Macro `STREAM_DEMUX_ERR_EN`, defined:
  - Ports `sel_err`, `err_cnt`, `err_clr` exist.
  - Each out-of-range handshake (`in_valid` && `in_sel` ≥ NCH) sets `sel_err` and increments `err_cnt`, which saturates at 255.
  - `err_clr` = 1 at an edge zeroes both.
  - If `err_clr` coincides with an error event, clear wins.
- Macro undefined:
  - Ports are absent.
  - Out-of-range words are still accepted and silently dropped.

## Test plan
- Reset, then `in_sel` swept 0..7 with data 8'hA0+i, all `out_ready` = 1. Required: `out_valid` one-hot at bit i one cycle later, slice i = 8'hA0+i, `in_ready` constant 1.
- Channel 3 with `out_ready[3]` = 0: send 8'h11 then 8'h22 to ch3. Required: first accepted, then `in_ready` = 0 and ch3 holds 8'h11. Meanwhile 8'h33 to ch5 is accepted. Raising `out_ready[3]` drains 8'h11 and accepts 8'h22 on the same edge.
- Back-to-back 16 words to ch0, `out_ready[0]` = 1. Required: 16 consecutive accepts, each word visible exactly one cycle, none lost.
- NCH=5, `in_sel` = 6 with 8'hFF. Required: `in_ready` = 1, no `out_valid` change. With `STREAM_DEMUX_ERR_EN` defined: `sel_err` = 1, `err_cnt` = 1. After 300 such words `err_cnt` = 255. `err_clr` returns both to 0.
- Fill ch2 and ch7 (`out_ready` = 0), then assert `rst_n` = 0 for one edge. Required: `out_valid` = 0, all `out_data` = 0, `in_ready` = 1 afterwards.
- `in_valid` = 0 with arbitrary `in_sel`/`in_data` for 20 cycles. Required: no state change, `err_cnt` unchanged.
